// File: rtl/debounce_if.sv
// Debouncer signal bundle: raw button level in, filtered level out.
// The driving side (button front end) uses master; the debouncer uses slave.
interface debounce_if;
  logic noisy;
  logic clean;

  modport master (output noisy, input  clean);
  modport slave  (input  noisy, output clean);
endinterface

// File: rtl/debounce.sv
// Two-flop synchronizer plus stability filter: clean follows noisy once it holds for DELAY cycles.
// Latency DELAY+3 cycles for rising and falling edges; level output, no backpressure.
module debounce #(
  parameter int unsigned DELAY = 100000,
  parameter int unsigned CW    = $clog2(DELAY) + 1
) (
  input logic       clk,
  input logic       rst_n,
  debounce_if.slave bus
);

  localparam logic [CW-1:0] CNT_LAST = CW'(DELAY - 1);

  logic          s1_q, s1_d;
  logic          s2_q, s2_d;
  logic          cand_q, cand_d;
  logic          clean_q, clean_d;
  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    s1_d    = bus.noisy;
    s2_d    = s1_q;
    cand_d  = cand_q;
    cnt_d   = cnt_q;
    clean_d = clean_q;
    // Any disagreement restarts the stability window; a full window commits the level.
    if (s2_q != cand_q) begin
      cand_d = s2_q;
      cnt_d  = '0;
    end else if (cnt_q == CNT_LAST) begin
      clean_d = cand_q;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q    <= 1'b0;
      s2_q    <= 1'b0;
      cand_q  <= 1'b0;
      cnt_q   <= '0;
      clean_q <= 1'b0;
    end else begin
      s1_q    <= s1_d;
      s2_q    <= s2_d;
      cand_q  <= cand_d;
      cnt_q   <= cnt_d;
      clean_q <= clean_d;
    end
  end

  assign bus.clean = clean_q;

endmodule

// File: tb/tb_debounce.sv
// Bench for debounce at DELAY=8: per-cycle scoreboard against a run-length model,
// segment table, latency probes, async reset and toggle corner cases.
module tb_debounce;
  localparam int DELAY = 8;
  localparam int LAT   = DELAY + 3;
  localparam int NSEG  = 12;

  logic clk;
  logic rst_n;
  debounce_if bus();

  debounce #(.DELAY(DELAY)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic lvl;
    int   cyc;
    logic exp_end;
  } seg_t;

  seg_t tbl [NSEG];
  logic exp_q [$];
  int   n_tests = 0;
  int   n_fail  = 0;
  int   cyc     = 0;

  // Model: clean takes the synchronized level once it has been seen DELAY+1 times in a row.
  logic m_s1, m_s2, m_clean;
  int   m_run;

  logic prev_clean;
  bit   have_change;
  int   last_change;

  task automatic check(input string nm, input logic act, input logic exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: clean=%0b expected %0b at cycle %0d", nm, act, exp, cyc);
    end
  endtask

  task automatic check_int(input string nm, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at cycle %0d", nm, act, exp, cyc);
    end
  endtask

  task automatic model_reset();
    m_s1        = 1'b0;
    m_s2        = 1'b0;
    m_clean     = 1'b0;
    m_run       = 1;
    prev_clean  = 1'b0;
    have_change = 1'b0;
  endtask

  task automatic model_edge(input logic n);
    if (!rst_n) begin
      model_reset();
    end else begin
      if (m_run >= DELAY + 1) m_clean = m_s2;
      if (m_s1 == m_s2) begin
        if (m_run < DELAY + 1) m_run++;
      end else begin
        m_run = 1;
      end
      m_s2 = m_s1;
      m_s1 = n;
    end
  endtask

  task automatic step(input logic n);
    logic e;
    bus.noisy = n;
    @(posedge clk);
    model_edge(n);
    exp_q.push_back(m_clean);
    #1;
    e = exp_q.pop_front();
    cyc++;
    check("sb", bus.clean, e);
    if (rst_n && bus.clean !== prev_clean) begin
      if (have_change)
        check_int("min_width", (cyc - last_change >= DELAY + 1) ? 1 : 0, 1);
      have_change = 1'b1;
      last_change = cyc;
      prev_clean  = bus.clean;
    end
  endtask

  task automatic measure(input logic lvl, output int lat);
    lat = -1;
    for (int i = 0; i < 40; i++) begin
      step(lvl);
      if (bus.clean === lvl) begin
        lat = i + 1;
        break;
      end
    end
  endtask

  task automatic run_table();
    for (int s = 0; s < NSEG; s++) begin
      for (int c = 0; c < tbl[s].cyc; c++) step(tbl[s].lvl);
      check($sformatf("tbl%0d", s), bus.clean, tbl[s].exp_end);
    end
  endtask

  initial begin
    int lat;
    logic c0;
    tbl[0]  = '{1'b1,  3, 1'b0};
    tbl[1]  = '{1'b0,  7, 1'b0};
    tbl[2]  = '{1'b1,  8, 1'b0};
    tbl[3]  = '{1'b0,  2, 1'b0};
    tbl[4]  = '{1'b1, 20, 1'b1};
    tbl[5]  = '{1'b0, 10, 1'b1};
    tbl[6]  = '{1'b0, 30, 1'b0};
    tbl[7]  = '{1'b1,  8, 1'b0};
    tbl[8]  = '{1'b0,  1, 1'b0};
    tbl[9]  = '{1'b1, 11, 1'b1};
    tbl[10] = '{1'b0, 10, 1'b1};
    tbl[11] = '{1'b0,  1, 1'b0};

    rst_n     = 1'b0;
    bus.noisy = 1'b1;
    model_reset();
    for (int i = 0; i < 100; i++) begin
      step(1'b1);
      check("rst_hold", bus.clean, 1'b0);
    end
    rst_n = 1'b1;

    measure(1'b1, lat);
    check_int("rise_lat", lat, LAT);
    for (int i = 0; i < 5; i++) step(1'b1);
    measure(1'b0, lat);
    check_int("fall_lat", lat, LAT);

    for (int r = 0; r < 4; r++) run_table();
    for (int i = 0; i < 400; i++) step(1'b0);
    check("idle", bus.clean, 1'b0);
    for (int r = 0; r < 4; r++) run_table();

    for (int i = 0; i < 15; i++) step(1'b1);
    check("pre_rst_hi", bus.clean, 1'b1);
    for (int i = 0; i < DELAY / 2; i++) step(1'b0);
    rst_n = 1'b0;
    model_reset();
    #1;
    check("async_rst", bus.clean, 1'b0);
    for (int i = 0; i < 3; i++) step(1'b1);
    rst_n = 1'b1;
    measure(1'b1, lat);
    check_int("post_rst_lat", lat, LAT);

    c0 = bus.clean;
    for (int i = 0; i < 100; i++) begin
      step(i[0]);
      check("toggle", bus.clean, c0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation exceeded time budget");
    $fatal(1);
  end

endmodule

// File: doc/debounce.md
# debounce

Single-input switch/button debouncer for the LED game front end. It takes a raw, asynchronous, bouncing `noisy` level from a pushbutton and synchronizes it to `clk`. It outputs `clean`, which changes only after the input has held a new level for a programmable number of consecutive clock cycles. Downstream game logic consumes `clean` as a glitch-free level (edge detection is done elsewhere).

## Interface

- `DELAY`, default 100000: required stable duration in `clk` cycles (1 ms at 100 MHz); legal range ≥ 2.
- `CW`, default `$clog2(DELAY)+1`: internal counter width; must hold `DELAY-1`.
- `clk`  input  1  system clock, 100 MHz nominal; all state updates on its rising edge.
- `rst_n`  input  1  asynchronous, active-low reset; release is synchronous to `clk` externally.
- `noisy`  input  1  raw button level, asynchronous to `clk`, may bounce.
- `clean`  output  1  debounced level, registered (driven directly by a flop).

## Operation

- Input synchronizer: two flops `s1 <= noisy`, `s2 <= s1`. Only `s2` feeds the filter.
- Filter state:
  - candidate register `cand` (1 bit);
  - counter `cnt` (`CW` bits);
  - output register `clean`.
- Per rising edge, with priority in the order listed:
  - If `s2 != cand`: `cand <= s2`, `cnt <= 0`; `clean` holds.
  - Else if `cnt == DELAY-1`: `clean <= cand`; `cnt` holds (saturates, no wrap).
  - Else: `cnt <= cnt + 1`; `clean` holds.
- Any input change before the count completes restarts the count from 0. Pulses or gaps shorter than `DELAY` cycles never reach `clean`.
- When `cand == clean` and the count saturates, re-writing `clean` is harmless; no glitch appears on `clean`.
- There are no other states and no enable input. The block is purely level-based.
- Reset (`rst_n` = 0, asynchronous):
  - `s1`, `s2`, `cand`, `clean` = 0;
  - `cnt` = 0.
  - Asserting reset mid-count aborts the count immediately. `clean` goes to 0 regardless of its prior value.
- After reset release with `noisy` held high: `clean` rises per the latency below. The block does not bypass the filter.

## Timing

- Let edge 1 be the first rising edge that samples a new `noisy` level into `s1`, with the level held thereafter. Then:
  - edge 2: `s2` updates;
  - edge 3: `cand` updates, `cnt` = 0;
  - edge `DELAY+2`: `cnt` reaches `DELAY-1`;
  - edge `DELAY+3`: `clean` takes the new level.
- Total latency is `DELAY+3` cycles: 1,000,030 ns at default settings, 11 cycles with `DELAY` = 8. The latency is identical for rising and falling transitions.
- A level change lasting N cycles at `s2`:
  - N ≤ `DELAY`: never propagates;
  - N ≥ `DELAY+1`: always propagates.
- Input toggling every cycle keeps `cnt` at 0 indefinitely, and `clean` holds.
- `clean` changes at most once per `DELAY+1` cycles.

## Test plan

- Reset: hold `rst_n` = 0 with `noisy` = 1 for 100 cycles -> `clean` = 0 throughout. Assert `rst_n` = 0 mid-count at cycle `DELAY/2` -> `clean` stays 0 and the count restarts after release.
- Glitch rejection (default `DELAY`): `noisy` high 50 µs, low 110 µs, high 210 µs, low 30 µs -> `clean` remains 0.
- Accept after bounce: continue with `noisy` high 2.02 ms -> `clean` rises exactly 1,000,030 ns after the last rising edge sampled in the 210 µs→30 µs→high sequence, and stays high.
- Release: `noisy` low 4.07 ms, then high 100 µs, then low 10 µs -> `clean` falls `DELAY+3` cycles after the 4.07 ms low begins, and ignores the 100 µs high pulse.
- Repeat the full burst pattern 4 times, then idle 50 ms, then run the same 4 bursts again -> every transition of `clean` matches the reference model. `clean` has no transition shorter than `DELAY+1` cycles.
- Boundary (`DELAY` = 8): hold `s2` at a new level for exactly 8 cycles -> no change; hold for 9 cycles -> `clean` changes at edge 11 after first sampling. Toggle every cycle for 100 cycles -> `clean` constant.
